// File: rtl/gray_step_cnt.sv
// Registered binary/Gray up-down counter with per-step changed-bit mask and wrap pulse.
// The Gray output is its own flop, so it can cross clock domains with no glitches.
module gray_step_cnt #(
  parameter int unsigned size = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            up,
  input  logic            load,
  input  logic [size-1:0] load_val,
  output logic [size-1:0] bin,
  output logic [size-1:0] gray,
  output logic [size-1:0] chg,
  output logic            tc
);

  localparam int unsigned W = size;
  localparam logic [W-1:0] cnt_max  = '1;
  localparam logic [W-1:0] cnt_zero = '0;

  logic [W-1:0] cnt;
  logic [W-1:0] gray_q;
  logic [W-1:0] chg_q;
  logic         tc_q;

  logic [W-1:0] cnt_next;
  logic [W-1:0] gray_next;
  logic [W-1:0] chg_next;
  logic         tc_next;

  // Next count: load beats a step; steps wrap silently at width W.
  always_comb begin
    cnt_next = cnt;
    tc_next  = 1'b0;
    if (load) begin
      cnt_next = load_val;
    end else if (en) begin
      if (up) begin
        cnt_next = cnt + W'(1);
        tc_next  = (cnt == cnt_max);
      end else begin
        cnt_next = cnt - W'(1);
        tc_next  = (cnt == cnt_zero);
      end
    end
  end

  // Encode the next count so gray lands on the same edge as bin.
  always_comb begin
    gray_next = cnt_next ^ (cnt_next >> 1);
    chg_next  = gray_next ^ gray_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      gray_q <= '0;
      chg_q  <= '0;
      tc_q   <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      gray_q <= gray_next;
      chg_q  <= chg_next;
      tc_q   <= tc_next;
    end
  end

  assign bin  = cnt;
  assign gray = gray_q;
  assign chg  = chg_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_gray_step_cnt.sv
// Bench for gray_step_cnt: integer model checked every negedge plus literal spot checks.
module tb_gray_step_cnt;

  localparam int unsigned SZ   = 4;
  localparam int          MODV = 1 << SZ;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          up = 1'b1;
  logic          load = 1'b0;
  logic [SZ-1:0] load_val = '0;
  logic [SZ-1:0] bin, gray, chg;
  logic          tc;

  int tests = 0;
  int fails = 0;

  // Model state: plain integers, gray/chg derived from the binary value.
  int mb = 0;
  int mc = 0;
  int mt = 0;

  int gseq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  gray_step_cnt #(.size(SZ)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .bin(bin), .gray(gray), .chg(chg), .tc(tc)
  );

  always #5 clk = ~clk;

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("bin",  int'(bin),  mb);
    chk("gray", int'(gray), gray_of(mb));
    chk("chg",  int'(chg),  mc);
    chk("tc",   int'(tc),   mt);
  end

  task automatic model_update(input bit e, input bit u, input bit ld, input int lv);
    int og;
    og = gray_of(mb);
    mt = 0;
    if (ld) mb = lv;
    else if (e) begin
      if (u) begin mt = (mb == MODV - 1); mb = (mb + 1) % MODV; end
      else   begin mt = (mb == 0);        mb = (mb + MODV - 1) % MODV; end
    end
    mc = gray_of(mb) ^ og;
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the rising edge.
  task automatic step(input bit e, input bit u, input bit ld, input int lv);
    en = e; up = u; load = ld; load_val = SZ'(lv);
    @(posedge clk);
    #1;
    model_update(e, u, ld, lv);
    if (e && !ld) chk("chg_onehot", $countones(chg), 1);
  endtask

  initial begin
    // Reset held with en high while the clock runs.
    en = 1'b1; up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bin", int'(bin), 0);
    chk("rst_gray", int'(gray), 0);
    rst_n = 1'b1;

    step(1, 1, 0, 0);
    chk("first_bin", int'(bin), 1);
    chk("first_gray", int'(gray), 1);
    chk("first_chg", int'(chg), 1);

    // Full up cycle back to zero.
    for (int k = 2; k <= 16; k++) begin
      step(1, 1, 0, 0);
      chk("up_gray_seq", int'(gray), gseq[k % 16]);
    end
    chk("wrap_up_chg", int'(chg), 8);
    chk("wrap_up_tc", int'(tc), 1);

    // Down wrap from zero.
    step(1, 0, 0, 0);
    chk("wrap_dn_bin", int'(bin), 15);
    chk("wrap_dn_gray", int'(gray), 8);
    chk("wrap_dn_chg", int'(chg), 8);
    chk("wrap_dn_tc", int'(tc), 1);
    step(1, 0, 0, 0);
    chk("dn14_gray", int'(gray), 9);
    chk("dn14_chg", int'(chg), 1);
    chk("dn14_tc", int'(tc), 0);

    // Load priority over en.
    step(0, 0, 1, 3);
    step(1, 1, 1, 10);
    chk("ld_bin", int'(bin), 10);
    chk("ld_gray", int'(gray), 15);
    chk("ld_chg", int'(chg), 13);
    chk("ld_tc", int'(tc), 0);
    step(1, 1, 1, 15);
    chk("ld15_tc", int'(tc), 0);
    step(1, 0, 1, 0);
    chk("ld0_tc", int'(tc), 0);
    step(0, 0, 1, 10);

    // Hold with up toggling; nothing moves.
    for (int k = 0; k < 5; k++) step(0, k[0], 0, 0);
    chk("hold_bin", int'(bin), 10);
    chk("hold_chg", int'(chg), 0);

    // Direction reversal every cycle.
    for (int k = 0; k < 6; k++) begin
      step(1, ~k[0], 0, 0);
      chk("alt_gray", int'(gray), k[0] ? 15 : 14);
      chk("alt_chg", int'(chg), 1);
    end

    // Async reset pulse between edges at bin=7.
    step(0, 0, 1, 6);
    step(1, 1, 0, 0);
    chk("pre_rst_bin", int'(bin), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_bin", int'(bin), 0);
    chk("async_gray", int'(gray), 0);
    chk("async_chg", int'(chg), 0);
    chk("async_tc", int'(tc), 0);
    mb = 0; mc = 0; mt = 0;
    #1 rst_n = 1'b1;
    step(1, 1, 0, 0);
    chk("resume_bin", int'(bin), 1);
    step(0, 1, 0, 0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
